// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// start/busy/done handshake; divide-by-zero completes one edge after start.
module divider #(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [width-1:0] dividend,
   input  logic [width-1:0] divisor,
   output logic [width-1:0] quotient,
   output logic [width-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = (width > 2) ? $clog2(width) : 1;
   localparam logic [CW-1:0] LAST = CW'(width - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [width:0]   r_q, r_d;
   logic [width-1:0] qsh_q, qsh_d;
   logic [width-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dz_q, dz_d;
   logic [width-1:0] quot_q, quot_d;
   logic [width-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [width:0]   r_sh, r_nx;
   logic [width-1:0] q_nx;
   logic             ge, accept;

   // One restoring step: shift in the next dividend bit, trial-subtract.
   always_comb begin
      r_sh = {r_q[width-1:0], qsh_q[width-1]};
      ge   = (r_sh >= {1'b0, dvs_q});
      r_nx = ge ? (r_sh - {1'b0, dvs_q}) : r_sh;
      q_nx = {qsh_q[width-2:0], ge};
   end

   // dz_q marks a pending divide-by-zero: the dividend waits in qsh_q for one
   // cycle so the completion lands one edge after the start edge.
   assign accept = start && !dz_q && ((state_q == S_IDLE) || (state_q == S_DONE));

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      qsh_d   = qsh_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (dz_q) begin
               state_d = S_DONE;
               quot_d  = '1;
               rem_d   = qsh_q;
               dbz_d   = 1'b1;
               dz_d    = 1'b0;
            end
         end
         S_CALC: begin
            r_d   = r_nx;
            qsh_d = q_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               quot_d  = q_nx;
               rem_d   = r_nx[width-1:0];
               dbz_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         qsh_d = dividend;
         dvs_d = divisor;
         r_d   = '0;
         cnt_d = '0;
         if (divisor != '0) begin
            state_d = S_CALC;
         end else begin
            state_d = S_IDLE;
            dz_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         qsh_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         qsh_q   <= qsh_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign busy        = (state_q == S_CALC);
   assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: 32-bit vector table, handshake corner cases,
// and a sampled 8-bit dividend/divisor sweep on a second instance.
module tb_divider;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] dividend = '0, divisor = '0;
   logic [31:0] quotient, remainder;
   logic        busy, done, div_by_zero;

   logic        s8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [7:0]  q8, r8;
   logic        busy8, done8, dbz8;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   divider #(.width(32)) dut (
      .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
      .div_by_zero(div_by_zero)
   );

   divider #(.width(8)) dut8 (
      .clk(clk), .reset(reset), .start(s8), .dividend(a8), .divisor(b8),
      .quotient(q8), .remainder(r8), .busy(busy8), .done(done8),
      .div_by_zero(dbz8)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk);
      #1;
      start = 1'b0; dividend = $urandom; divisor = $urandom;
   endtask

   // Counts edges from the current cycle until done; bz accumulates busy cycles.
   task automatic wait_done(output int lat, output int bz);
      lat = 0;
      bz  = busy ? 1 : 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
         bz += busy ? 1 : 0;
      end
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
      @(negedge clk);
      s8 = 1'b1; a8 = a; b8 = b;
      @(posedge clk);
      #1;
      s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (done8) break;
      end
   endtask

   initial begin
      vec_t vt[8];
      int lat, bz, dn;
      logic [7:0] ea, eb;
      logic [7:0] eq, er;
      logic       edz;
      int         elat;

      vt[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2, dz: 1'b0};
      vt[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0, dz: 1'b0};
      vt[2] = '{a: 32'd3,          b: 32'd10,         q: 32'd0,          r: 32'd3, dz: 1'b0};
      vt[3] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0, dz: 1'b0};
      vt[4] = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd5, dz: 1'b1};
      vt[5] = '{a: 32'd50,         b: 32'd6,          q: 32'd8,          r: 32'd2, dz: 1'b0};
      vt[6] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0, dz: 1'b0};
      vt[7] = '{a: 32'h8000_0000,  b: 32'd3,          q: 32'h2AAA_AAAA,  r: 32'd2, dz: 1'b0};

      repeat (2) @(posedge clk);
      #1;
      check("reset_q",    64'(quotient), 64'd0);
      check("reset_r",    64'(remainder), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_dbz",  64'(div_by_zero), 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         launch(vt[i].a, vt[i].b);
         wait_done(lat, bz);
         check($sformatf("v%0d_q", i),   64'(quotient), 64'(vt[i].q));
         check($sformatf("v%0d_r", i),   64'(remainder), 64'(vt[i].r));
         check($sformatf("v%0d_dbz", i), 64'(div_by_zero), 64'(vt[i].dz));
         check($sformatf("v%0d_lat", i), 64'(lat), vt[i].dz ? 64'd1 : 64'd32);
         check($sformatf("v%0d_busy", i), 64'(bz), vt[i].dz ? 64'd0 : 64'd32);
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("v%0d_pulse", i), 64'(done), 64'd0);
         check($sformatf("v%0d_hold", i),  64'({quotient, remainder}), {vt[i].q, vt[i].r});
      end

      // start during CALC must be ignored
      launch(32'd100, 32'd7);
      start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, bz);
      check("midcalc_q",   64'(quotient), 64'd14);
      check("midcalc_r",   64'(remainder), 64'd2);
      check("midcalc_lat", 64'(lat), 64'd31);
      // back-to-back start taken in the DONE cycle
      launch(32'd9, 32'd3);
      wait_done(lat, bz);
      check("b2b_q",   64'(quotient), 64'd3);
      check("b2b_r",   64'(remainder), 64'd0);
      check("b2b_lat", 64'(lat), 64'd32);

      // reset mid-CALC aborts with no done pulse
      launch(32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_q",    64'(quotient), 64'd0);
      check("abort_r",    64'(remainder), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      reset = 1'b0;
      dn = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         dn += done ? 1 : 0;
      end
      check("abort_nodone", 64'(dn), 64'd0);
      launch(32'd50, 32'd6);
      wait_done(lat, bz);
      check("fresh_q",   64'(quotient), 64'd8);
      check("fresh_r",   64'(remainder), 64'd2);
      check("fresh_lat", 64'(lat), 64'd32);

      // sampled width-8 sweep; j=0 is divide-by-zero, 20/21 hit 1 and 255
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 22; j++) begin
            ea = 8'(i * 17);
            eb = (j == 20) ? 8'd1 : (j == 21) ? 8'd255 : 8'(j * 13);
            if (eb == 8'd0) begin
               eq = 8'hFF; er = ea; edz = 1'b1; elat = 1;
            end else begin
               eq = ea / eb; er = ea % eb; edz = 1'b0; elat = 8;
            end
            run8(ea, eb, lat);
            check($sformatf("w8_%0d_%0d", ea, eb), {31'd0, q8, r8, dbz8, 8'(lat)},
                  {31'd0, eq, er, edz, 8'(elat)});
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
